// File: rtl/k_fp16_pkg.sv
// Shared FP16 definitions for the k-means distance datapath.
// Holds the field constants, canonical special encodings and operand class.
// Contains one helper function that classifies an exponent/mantissa pair.
package k_fp16_pkg;

    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int EXP_BIAS = 15;
    localparam int EXP_MAX  = 31;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;
    localparam logic [15:0] MAXF = 16'h7BFF;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } class_t;

    // Subnormals (E==0, M!=0) are flushed and reported as ZERO.
    function automatic class_t fp16_classify(input logic [EXP_W-1:0]  e,
                                             input logic [MANT_W-1:0] m);
        class_t c;
        c = NORM;
        if (e == '0) begin
            c = ZERO;
        end else if (e == EXP_W'(EXP_MAX)) begin
            c = (m == '0) ? INF : NAN;
        end
        return c;
    endfunction

endpackage

// File: rtl/k_4_msq.sv
// Combinational mantissa-square estimator: q_o ~= (m_i*m_i)>>10.
// Latency 0 (pure combinational); no handshake, no backpressure.
// Ports: m_i = 10-bit FP16 fraction, q_o = 10-bit estimate of its square.
module k_4_msq
    import k_fp16_pkg::*;
#(
    parameter bit APPROX_EN = 1'b1
) (
    input  logic [MANT_W-1:0] m_i,
    output logic [MANT_W-1:0] q_o
);

    always_comb begin
        q_o = '0;
        if (APPROX_EN) begin
            // Piecewise-linear fit of m^2 over four equal segments of m,
            // chosen so every term is a power-of-two shift of m.
            case (m_i[9:8])
                2'd0:    q_o = m_i >> 3;
                2'd1:    q_o = (m_i >> 2) + (m_i >> 3);
                2'd2:    q_o = (m_i >> 1) + (m_i >> 3);
                default: q_o = m_i - (m_i >> 3);
            endcase
        end else begin
            // Exact floor((m*m)/1024); never exceeds 1022 so it fits 10 bits.
            q_o = MANT_W'(({10'd0, m_i} * {10'd0, m_i}) >> 10);
        end
    end

endmodule

// File: rtl/k_4_square.sv
// Approximate FP16 squarer, out ~= in*in, sign always cleared.
// Latency 3 advancing cycles, throughput 1/cycle; global stall while done & !out_ready.
// Ports: clk/rst_n (sync, active low), en/in_ready/in in, done/out_ready/out out.
module k_4_square
    import k_fp16_pkg::*;
#(
    parameter bit APPROX_EN = 1'b1,
    parameter bit SAT_INF   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        in_ready,
    input  logic [15:0] in,
    output logic        done,
    input  logic        out_ready,
    output logic [15:0] out
);

    logic               advance;

    logic               s1_vld_q, s1_vld_d;
    logic               s2_vld_q, s2_vld_d;
    logic               s3_vld_q, s3_vld_d;

    logic [EXP_W-1:0]   s1_exp_q, s1_exp_d;
    logic [MANT_W-1:0]  s1_man_q, s1_man_d;
    class_t             s1_cls_q, s1_cls_d;

    logic [MANT_W-1:0]  msq;
    logic [11:0]        s2_f_q, s2_f_d;
    logic signed [6:0]  s2_er_q, s2_er_d;
    class_t             s2_cls_q, s2_cls_d;

    logic signed [6:0]  s3_er;
    logic [MANT_W-1:0]  s3_mant;
    logic [15:0]        s3_res;
    logic [15:0]        out_q, out_d;

    // A square is never negative, so the operand sign plays no part.
    logic               unused_sign;
    assign unused_sign = in[15];

    // Single stall domain: the whole pipe moves only when the output slot frees.
    assign advance  = !s3_vld_q || out_ready;
    assign in_ready = advance;
    assign done     = s3_vld_q;
    assign out      = out_q;

    k_4_msq #(
        .APPROX_EN(APPROX_EN)
    ) u_msq (
        .m_i(s1_man_q),
        .q_o(msq)
    );

    // S3 normalise and pack from the S2 registers.
    always_comb begin
        s3_er   = s2_er_q;
        s3_mant = s2_f_q[9:0];
        // f in [2048,4095] means the square reached [2,4): renormalise by one.
        if (s2_f_q[11]) begin
            s3_mant = s2_f_q[10:1];
            s3_er   = s2_er_q + 7'sd1;
        end
        s3_res = {1'b0, s3_er[4:0], s3_mant};
        if (s3_er >= 7'sd31) begin
            s3_res = SAT_INF ? PINF : MAXF;
        end else if (s3_er <= 7'sd0) begin
            s3_res = '0;
        end
        case (s2_cls_q)
            ZERO:    s3_res = '0;
            INF:     s3_res = PINF;
            NAN:     s3_res = QNAN;
            default: ;
        endcase
    end

    // Next-state for all stages.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        s3_vld_d = s3_vld_q;
        s1_exp_d = s1_exp_q;
        s1_man_d = s1_man_q;
        s1_cls_d = s1_cls_q;
        s2_f_d   = s2_f_q;
        s2_er_d  = s2_er_q;
        s2_cls_d = s2_cls_q;
        out_d    = out_q;
        if (advance) begin
            s1_vld_d = en;
            s2_vld_d = s1_vld_q;
            s3_vld_d = s2_vld_q;
            s1_exp_d = in[14:10];
            s1_man_d = in[9:0];
            s1_cls_d = fp16_classify(in[14:10], in[9:0]);
            // (1+m)^2 = 1 + 2m + m^2 in 2^-10 units.
            s2_f_d   = 12'd1024 + {1'b0, s1_man_q, 1'b0} + {2'b00, msq};
            // Unbiased exponent doubles; re-bias once: 2(E-15)+15.
            s2_er_d  = $signed({1'b0, s1_exp_q, 1'b0}) - 7'sd15;
            s2_cls_d = s1_cls_q;
            // Output only changes on a real result so a bubble keeps the last value.
            if (s2_vld_q) begin
                out_d = s3_res;
            end
        end
    end

    // Control state: valids and output register are reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
            out_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            s3_vld_q <= s3_vld_d;
            out_q    <= out_d;
        end
    end

    // Stage data is qualified by the valids and needs no reset.
    always_ff @(posedge clk) begin
        s1_exp_q <= s1_exp_d;
        s1_man_q <= s1_man_d;
        s1_cls_q <= s1_cls_d;
        s2_f_q   <= s2_f_d;
        s2_er_q  <= s2_er_d;
        s2_cls_q <= s2_cls_d;
    end

endmodule
